// File: rtl/eth_10g_mac_tx_pause_quanta_timer.sv
// eth_10g_mac_tx_pause_quanta_timer: 802.3x TX pause timer; holds TX off for quanta*CYCLES_PER_QUANTA cycles from a frame boundary
module eth_10g_mac_tx_pause_quanta_timer #(
  parameter int CYCLES_PER_QUANTA = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid_i,
  input  logic [15:0] in_data_i,
  output logic        in_ready_o,
  input  logic        tx_frame_active_i,
  output logic        tx_pause_active_o,
  output logic [15:0] pause_quanta_remaining_o,
  output logic [15:0] pause_count_o
);
  typedef enum logic [1:0] {IDLE, WAIT_EOF, PAUSED} state_t;
  localparam logic [7:0] RELOAD = 8'(CYCLES_PER_QUANTA - 1);
  state_t      state_q, state_d;
  logic [7:0]  sub_q, sub_d;
  logic [15:0] rem_q, rem_d, held_q, held_d, cnt_q, cnt_d;
  logic        ready_q, xon, req;
  assign xon = in_valid_i & ready_q & (in_data_i == 16'd0);
  assign req = in_valid_i & ready_q & (in_data_i != 16'd0);
  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    rem_d   = rem_q;
    held_d  = held_q;
    cnt_d   = cnt_q + {15'd0, req & (cnt_q != 16'hFFFF)};
    case (state_q)
      IDLE:
        if (req && tx_frame_active_i) begin
          state_d = WAIT_EOF;
          held_d  = in_data_i;
        end else if (req) begin
          state_d = PAUSED;
          rem_d   = in_data_i;
          sub_d   = RELOAD;
        end
      WAIT_EOF:
        if (xon) state_d = IDLE;
        else if (!tx_frame_active_i) begin
          state_d = PAUSED;
          rem_d   = req ? in_data_i : held_q;
          sub_d   = RELOAD;
        end else if (req) held_d = in_data_i;
      PAUSED:
        if (xon) begin
          state_d = IDLE;
          rem_d   = 16'd0;
          sub_d   = 8'd0;
        end else if (req) begin
          rem_d = in_data_i;
          sub_d = RELOAD;
        end else if (sub_q != 8'd0) sub_d = sub_q - 8'd1;
        else if (rem_q == 16'd1) begin
          state_d = IDLE;
          rem_d   = 16'd0;
        end else begin
          rem_d = rem_q - 16'd1;
          sub_d = RELOAD;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sub_q   <= 8'd0;
      rem_q   <= 16'd0;
      held_q  <= 16'd0;
      cnt_q   <= 16'd0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
      rem_q   <= rem_d;
      held_q  <= held_d;
      cnt_q   <= cnt_d;
      ready_q <= 1'b1;
    end
  end
  assign in_ready_o               = ready_q;
  assign tx_pause_active_o        = (state_q == PAUSED);
  assign pause_quanta_remaining_o = rem_q;
  assign pause_count_o            = cnt_q;
endmodule

// File: tb/tb_eth_10g_mac_tx_pause_quanta_timer.sv
// tb_eth_10g_mac_tx_pause_quanta_timer: two timers (8 and 1 cycles/quantum) checked against a timestamp model
module tb_eth_10g_mac_tx_pause_quanta_timer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0, total = 0, bad = 0;
  logic rA, vA, fA, rdyA, actA, rB, vB, fB, rdyB, actB;
  logic [15:0] dA, remA, cntA, dB, remB, cntB;
  eth_10g_mac_tx_pause_quanta_timer #(.CYCLES_PER_QUANTA(8)) dut_a (
    .clk(clk), .reset(rA), .in_valid_i(vA), .in_data_i(dA), .in_ready_o(rdyA),
    .tx_frame_active_i(fA), .tx_pause_active_o(actA),
    .pause_quanta_remaining_o(remA), .pause_count_o(cntA));
  eth_10g_mac_tx_pause_quanta_timer #(.CYCLES_PER_QUANTA(1)) dut_b (
    .clk(clk), .reset(rB), .in_valid_i(vB), .in_data_i(dB), .in_ready_o(rdyB),
    .tx_frame_active_i(fB), .tx_pause_active_o(actB),
    .pause_quanta_remaining_o(remB), .pause_count_o(cntB));
  // model: mode 0 idle, 1 waiting for frame end, 2 paused from cycle m_start for m_q quanta
  int m_mode[2], m_q[2], m_start[2], m_held[2], m_cnt[2], m_rdy[2];
  int cpq[2] = '{8, 1};
  task automatic chk(input string n, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s at cycle %0d: got=%0d want=%0d", n, cyc, a, e);
    end
  endtask
  task automatic model_step(input int i, input logic r, input logic v, input logic [15:0] d,
                            input logic fa, input int t);
    int om;
    bit acc;
    if (r) begin
      m_mode[i] = 0;
      m_rdy[i]  = 0;
      m_cnt[i]  = 0;
      return;
    end
    acc = v && (m_rdy[i] != 0);
    m_rdy[i] = 1;
    om = m_mode[i];
    if (om == 2 && t >= m_start[i] + m_q[i] * cpq[i]) m_mode[i] = 0;
    if (acc && d == 16'd0) m_mode[i] = 0;
    else if (acc) begin
      if (m_cnt[i] < 65535) m_cnt[i]++;
      if (om == 2 || !fa) begin
        m_mode[i] = 2;
        m_start[i] = t;
        m_q[i] = int'(d);
      end else begin
        m_mode[i] = 1;
        m_held[i] = int'(d);
      end
    end else if (om == 1 && !fa) begin
      m_mode[i] = 2;
      m_start[i] = t;
      m_q[i] = m_held[i];
    end
  endtask
  always @(posedge clk) begin
    model_step(0, rA, vA, dA, fA, cyc + 1);
    model_step(1, rB, vB, dB, fB, cyc + 1);
    cyc <= cyc + 1;
  end
  task automatic cmp(input int i, input logic act, input logic [15:0] rem, input logic [15:0] cnt,
                     input logic rdy);
    int e_rem;
    e_rem = (m_mode[i] == 2) ? m_q[i] - (cyc - m_start[i]) / cpq[i] : 0;
    chk(i == 0 ? "A_active" : "B_active", int'(act), m_mode[i] == 2 ? 1 : 0);
    chk(i == 0 ? "A_remaining" : "B_remaining", int'(rem), e_rem);
    chk(i == 0 ? "A_count" : "B_count", int'(cnt), m_cnt[i]);
    chk(i == 0 ? "A_ready" : "B_ready", int'(rdy), m_rdy[i]);
  endtask
  always @(negedge clk) begin
    if (cyc >= 1) begin
      cmp(0, actA, remA, cntA, rdyA);
      cmp(1, actB, remB, cntB, rdyB);
    end
  end
  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask
  task automatic drv_a(input int at, input logic v, input int d, input logic f);
    wait_cyc(at);
    vA = v;
    dA = 16'(d);
    fA = f;
  endtask
  task automatic drv_b(input int at, input logic v, input int d, input logic f);
    wait_cyc(at);
    vB = v;
    dB = 16'(d);
    fB = f;
  endtask
  initial begin
    rA = 1; vA = 0; dA = 0; fA = 0;
    rB = 1; vB = 0; dB = 0; fB = 0;
    fork
      begin
        wait_cyc(2);
        chk("A_lit_rst_ready", int'(rdyA), 0);
        chk("A_lit_rst_count", int'(cntA), 0);
        wait_cyc(3); rA = 0;
        wait_cyc(4); chk("A_lit_ready_up", int'(rdyA), 1);
        drv_a(10, 1, 3, 0); drv_a(11, 0, 0, 0);
        chk("A_lit_q3_active", int'(actA), 1);
        chk("A_lit_q3_rem11", int'(remA), 3);
        chk("A_lit_q3_count", int'(cntA), 1);
        wait_cyc(19); chk("A_lit_q3_rem19", int'(remA), 2);
        wait_cyc(27); chk("A_lit_q3_rem27", int'(remA), 1);
        wait_cyc(34); chk("A_lit_q3_last", int'(actA), 1);
        wait_cyc(35); chk("A_lit_q3_end", int'(actA), 0);
        drv_a(40, 1, 2, 1); drv_a(41, 0, 0, 1);
        wait_cyc(45); chk("A_lit_wait_inactive", int'(actA), 0);
        chk("A_lit_wait_rem", int'(remA), 0);
        drv_a(50, 0, 0, 0); chk("A_lit_eof_cycle", int'(actA), 0);
        wait_cyc(51); chk("A_lit_eof_rise", int'(actA), 1);
        chk("A_lit_eof_rem", int'(remA), 2);
        wait_cyc(66); chk("A_lit_eof_last", int'(actA), 1);
        wait_cyc(67); chk("A_lit_eof_fall", int'(actA), 0);
        drv_a(80, 1, 100, 0); drv_a(81, 0, 0, 0);
        wait_cyc(110); chk("A_lit_q100_rem", int'(remA), 97);
        drv_a(110, 1, 0, 0); drv_a(111, 0, 0, 0);
        chk("A_lit_xon_active", int'(actA), 0);
        chk("A_lit_xon_rem", int'(remA), 0);
        chk("A_lit_xon_count", int'(cntA), 3);
        drv_a(120, 1, 1, 0); drv_a(121, 0, 0, 0);
        drv_a(128, 1, 5, 0); drv_a(129, 0, 0, 0);
        chk("A_lit_race_rem", int'(remA), 5);
        chk("A_lit_race_count", int'(cntA), 5);
        wait_cyc(168); chk("A_lit_race_last", int'(actA), 1);
        wait_cyc(169); chk("A_lit_race_end", int'(actA), 0);
        drv_a(180, 1, 0, 0); drv_a(181, 0, 0, 0);
        chk("A_lit_idle_xon_count", int'(cntA), 5);
        drv_a(190, 1, 4, 1); drv_a(191, 0, 0, 1);
        drv_a(195, 1, 7, 1); drv_a(196, 0, 0, 1);
        chk("A_lit_wait_replace_count", int'(cntA), 7);
        drv_a(198, 1, 0, 1); drv_a(199, 0, 0, 1); drv_a(200, 0, 0, 0);
        wait_cyc(202); chk("A_lit_wait_xon", int'(actA), 0);
        drv_a(210, 1, 4, 1); drv_a(211, 0, 0, 1);
        drv_a(212, 1, 2, 1); drv_a(213, 0, 0, 1); drv_a(215, 0, 0, 0);
        wait_cyc(216); chk("A_lit_replaced_rem", int'(remA), 2);
        chk("A_lit_replaced_count", int'(cntA), 9);
        wait_cyc(231); chk("A_lit_replaced_last", int'(actA), 1);
        wait_cyc(232); chk("A_lit_replaced_end", int'(actA), 0);
        drv_a(300, 1, 1, 0);
        wait_cyc(301); chk("A_lit_sat_start", int'(cntA), 10);
        wait_cyc(65825); chk("A_lit_sat_below", int'(cntA), 65534);
        drv_a(65836, 0, 0, 0);
        wait_cyc(65840); chk("A_lit_sat_hold", int'(cntA), 65535);
        wait_cyc(65850); rA = 1; vA = 1; dA = 9;
        wait_cyc(65851); vA = 0;
        wait_cyc(65852); vA = 1;
        chk("A_lit_rst_pulse_count", int'(cntA), 0);
        chk("A_lit_rst_pulse_ready", int'(rdyA), 0);
        wait_cyc(65853); vA = 0;
        wait_cyc(65855); rA = 0;
        wait_cyc(65856); chk("A_lit_rel_ready", int'(rdyA), 1);
        chk("A_lit_rel_count", int'(cntA), 0);
      end
      begin
        wait_cyc(3); rB = 0;
        drv_b(10, 1, 65535, 0); drv_b(11, 0, 0, 0);
        chk("B_lit_max_active", int'(actB), 1);
        chk("B_lit_max_rem", int'(remB), 65535);
        wait_cyc(1000); chk("B_lit_max_rem1000", int'(remB), 64546);
        wait_cyc(65545); chk("B_lit_max_last", int'(actB), 1);
        chk("B_lit_max_last_rem", int'(remB), 1);
        wait_cyc(65546); chk("B_lit_max_end", int'(actB), 0);
        drv_b(65560, 1, 500, 0); drv_b(65561, 0, 0, 0);
        wait_cyc(65562); chk("B_lit_q500_rem", int'(remB), 499);
        chk("B_lit_q500_count", int'(cntB), 2);
        wait_cyc(65600); rB = 1;
        wait_cyc(65601); chk("B_lit_rst_active", int'(actB), 0);
        chk("B_lit_rst_rem", int'(remB), 0);
        chk("B_lit_rst_count", int'(cntB), 0);
        chk("B_lit_rst_ready", int'(rdyB), 0);
        wait_cyc(65605); rB = 0;
        wait_cyc(65606); chk("B_lit_rel_ready", int'(rdyB), 1);
      end
    join
    wait_cyc(65870);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
